// File: rtl/sgn_exp_pipe_if.sv
// ---------------------------------------------------------------------------
// sgn_exp_pipe_if
//   Operand/result bus of the sign/exponent pipeline stage of the multiplier.
//
//   Parameter
//     EXP_W      exponent field width in bits
//
//   Signals
//     in_valid   operand pair valid                    (master -> slave)
//     in_ready   stage can accept the pair this cycle  (slave  -> master)
//     sa, sb     operand signs                         (master -> slave)
//     expa, expb biased operand exponents              (master -> slave)
//     mnza, mnzb operand mantissa fields non-zero      (master -> slave)
//     out_valid  result valid                          (slave  -> master)
//     out_ready  downstream accepts the result         (master -> slave)
//     out_sgn    product sign                          (slave  -> master)
//     out_exp    signed exponent result, EXP_W+2 bits  (slave  -> master)
//     out_zero / out_inf / out_nan / out_ovf / out_unf result class flags
//
//   Modports
//     master     operand producer and result consumer
//     slave      the pipeline itself
// ---------------------------------------------------------------------------
interface sgn_exp_pipe_if #(
   parameter int EXP_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             sa;
   logic             sb;
   logic [EXP_W-1:0] expa;
   logic [EXP_W-1:0] expb;
   logic             mnza;
   logic             mnzb;

   logic             out_valid;
   logic             out_ready;
   logic             out_sgn;
   logic [EXP_W+1:0] out_exp;
   logic             out_zero;
   logic             out_inf;
   logic             out_nan;
   logic             out_ovf;
   logic             out_unf;

   modport master (
      output in_valid, sa, sb, expa, expb, mnza, mnzb, out_ready,
      input  in_ready, out_valid, out_sgn, out_exp,
             out_zero, out_inf, out_nan, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, sa, sb, expa, expb, mnza, mnzb, out_ready,
      output in_ready, out_valid, out_sgn, out_exp,
             out_zero, out_inf, out_nan, out_ovf, out_unf
   );
endinterface

// File: rtl/sgn_exp_pipe.sv
// ---------------------------------------------------------------------------
// sgn_exp_pipe
//   Two-stage pipelined sign / exponent stage of the approximate FP
//   multiplier. Produces the product sign, the rebiased exponent sum
//   (expa + expb - BIAS, signed, EXP_W+2 bits so it never wraps), the
//   special-operand result class and exponent overflow/underflow flags.
//
//   Parameters
//     EXP_W      exponent field width (8 for BFloat16)
//     BIAS       exponent bias, 0 <= BIAS < 2**EXP_W
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        sgn_exp_pipe_if.slave: valid/ready operand input,
//                valid/ready result output and result fields
//
//   Build option
//     SGN_EXP_SAT_EN  when defined, out_exp is saturated: all-ones exponent
//                     (2**EXP_W-1) for ovf/inf/nan, 0 for unf/zero.
//                     Undefined (default): out_exp always carries raw.
//
//   Pipeline
//     stage 1: sign, raw exponent, per-operand class bits
//     stage 2: resolved flags and final out_exp (the output registers)
//   Stage 2 advances when empty or out_ready; stage 1 advances when empty
//   or stage 2 advances. in_ready is therefore combinational from out_ready.
// ---------------------------------------------------------------------------
module sgn_exp_pipe #(
   parameter int EXP_W = 8,
   parameter int BIAS  = 127
) (
   input  logic           clk,
   input  logic           rst_n,
   sgn_exp_pipe_if.slave  bus
);

   localparam int RW = EXP_W + 2;

   localparam logic [RW-1:0]    BIAS_R   = RW'(BIAS);
   localparam logic [RW-1:0]    EXP_MAX  = RW'((1 << EXP_W) - 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   // ------------------------------------------------------------------
   // Flow control
   // ------------------------------------------------------------------
   logic v1;
   logic v2;
   logic adv1;
   logic adv2;

   assign adv2        = !v2 || bus.out_ready;
   assign adv1        = !v1 || adv2;
   assign bus.in_ready = adv1;

   // ------------------------------------------------------------------
   // Stage 0 (combinational): raw exponent and operand classes
   // ------------------------------------------------------------------
   logic [RW-1:0] raw_c;
   logic          ones_a;
   logic          ones_b;
   logic          zero_a_c;
   logic          zero_b_c;
   logic          inf_a_c;
   logic          inf_b_c;
   logic          nan_a_c;
   logic          nan_b_c;

   // Zero-extended operands leave two spare bits, so the sum minus BIAS
   // stays representable in RW-bit two's complement for every input.
   assign raw_c    = {2'b00, bus.expa} + {2'b00, bus.expb} - BIAS_R;

   assign ones_a   = (bus.expa == EXP_ONES);
   assign ones_b   = (bus.expb == EXP_ONES);
   // Subnormals flush to zero, so the mantissa flag is irrelevant here.
   assign zero_a_c = (bus.expa == '0);
   assign zero_b_c = (bus.expb == '0);
   assign inf_a_c  = ones_a && !bus.mnza;
   assign inf_b_c  = ones_b && !bus.mnzb;
   assign nan_a_c  = ones_a &&  bus.mnza;
   assign nan_b_c  = ones_b &&  bus.mnzb;

   // ------------------------------------------------------------------
   // Stage 1 registers
   // ------------------------------------------------------------------
   logic          s1_sgn;
   logic [RW-1:0] s1_raw;
   logic          s1_zero_a;
   logic          s1_zero_b;
   logic          s1_inf_a;
   logic          s1_inf_b;
   logic          s1_nan_a;
   logic          s1_nan_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         s1_sgn    <= 1'b0;
         s1_raw    <= '0;
         s1_zero_a <= 1'b0;
         s1_zero_b <= 1'b0;
         s1_inf_a  <= 1'b0;
         s1_inf_b  <= 1'b0;
         s1_nan_a  <= 1'b0;
         s1_nan_b  <= 1'b0;
      end else if (adv1) begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sgn    <= bus.sa ^ bus.sb;
            s1_raw    <= raw_c;
            s1_zero_a <= zero_a_c;
            s1_zero_b <= zero_b_c;
            s1_inf_a  <= inf_a_c;
            s1_inf_b  <= inf_b_c;
            s1_nan_a  <= nan_a_c;
            s1_nan_b  <= nan_b_c;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1 -> 2 (combinational): result class resolution
   // ------------------------------------------------------------------
   logic          nan_c;
   logic          inf_c;
   logic          zero_c;
   logic          normal_c;
   logic          ovf_c;
   logic          unf_c;
   logic [RW-1:0] exp_c;

   // inf * 0 is invalid and resolves to NaN ahead of the inf class.
   assign nan_c    = s1_nan_a || s1_nan_b
                     || (s1_inf_a && s1_zero_b) || (s1_inf_b && s1_zero_a);
   assign inf_c    = !nan_c && (s1_inf_a || s1_inf_b);
   assign zero_c   = !nan_c && !inf_c && (s1_zero_a || s1_zero_b);
   assign normal_c = !nan_c && !inf_c && !zero_c;

   // Signed compares done on the sign bit plus an unsigned magnitude test.
   assign ovf_c    = normal_c && !s1_raw[RW-1] && (s1_raw >= EXP_MAX);
   assign unf_c    = normal_c && (s1_raw[RW-1] || (s1_raw == '0));

`ifdef SGN_EXP_SAT_EN
   always_comb begin
      exp_c = s1_raw;
      if (ovf_c || inf_c || nan_c) begin
         exp_c = EXP_MAX;
      end else if (unf_c || zero_c) begin
         exp_c = '0;
      end
   end
`else
   assign exp_c = s1_raw;
`endif

   // ------------------------------------------------------------------
   // Stage 2 registers (drive the outputs directly)
   // ------------------------------------------------------------------
   logic          s2_sgn;
   logic [RW-1:0] s2_exp;
   logic          s2_zero;
   logic          s2_inf;
   logic          s2_nan;
   logic          s2_ovf;
   logic          s2_unf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2      <= 1'b0;
         s2_sgn  <= 1'b0;
         s2_exp  <= '0;
         s2_zero <= 1'b0;
         s2_inf  <= 1'b0;
         s2_nan  <= 1'b0;
         s2_ovf  <= 1'b0;
         s2_unf  <= 1'b0;
      end else if (adv2) begin
         v2 <= v1;
         // Data only moves with a valid entry, so a drained output keeps
         // its last value and a stalled one is never disturbed.
         if (v1) begin
            s2_sgn  <= s1_sgn;
            s2_exp  <= exp_c;
            s2_zero <= zero_c;
            s2_inf  <= inf_c;
            s2_nan  <= nan_c;
            s2_ovf  <= ovf_c;
            s2_unf  <= unf_c;
         end
      end
   end

   assign bus.out_valid = v2;
   assign bus.out_sgn   = s2_sgn;
   assign bus.out_exp   = s2_exp;
   assign bus.out_zero  = s2_zero;
   assign bus.out_inf   = s2_inf;
   assign bus.out_nan   = s2_nan;
   assign bus.out_ovf   = s2_ovf;
   assign bus.out_unf   = s2_unf;

endmodule

// File: tb/tb_sgn_exp_pipe.sv
// ---------------------------------------------------------------------------
// tb_sgn_exp_pipe
//   Scoreboard bench for sgn_exp_pipe (EXP_W=8, BIAS=127). Expected results
//   are hand-computed constants in the vector table; the stimulus side pushes
//   them when a pair is accepted and the monitor pops on every output
//   transfer. The monitor also checks that outputs hold during stalls.
// ---------------------------------------------------------------------------
module tb_sgn_exp_pipe;

   localparam int EXP_W = 8;
   localparam int NVEC  = 17;

   logic clk;
   logic rst_n;

   sgn_exp_pipe_if #(.EXP_W(EXP_W)) bus ();

   sgn_exp_pipe #(.EXP_W(EXP_W), .BIAS(127)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // flags order: {nan, inf, zero, ovf, unf}
   typedef struct {
      logic       sa;
      logic       sb;
      logic [7:0] expa;
      logic [7:0] expb;
      logic       mnza;
      logic       mnzb;
      logic       e_sgn;
      logic [9:0] e_raw;
      logic [9:0] e_sat;
      logic [4:0] e_flags;
   } vec_t;

   vec_t vecs [NVEC];

   logic [15:0] sb_q [$];
   int          checks;
   int          errors;
   int          rmode;
   int          pidx;
   bit          pat [7];

   function automatic vec_t mk(input logic sa, input logic sb,
                               input logic [7:0] ea, input logic [7:0] eb,
                               input logic ma, input logic mb,
                               input logic es, input logic [9:0] er,
                               input logic [9:0] esat, input logic [4:0] ef);
      vec_t v;
      v.sa = sa; v.sb = sb; v.expa = ea; v.expb = eb; v.mnza = ma; v.mnzb = mb;
      v.e_sgn = es; v.e_raw = er; v.e_sat = esat; v.e_flags = ef;
      return v;
   endfunction

   function automatic logic [15:0] expv(input int i);
      logic [9:0] e;
`ifdef SGN_EXP_SAT_EN
      e = vecs[i].e_sat;
`else
      e = vecs[i].e_raw;
`endif
      return {vecs[i].e_sgn, e, vecs[i].e_flags};
   endfunction

   function automatic logic [15:0] got_bundle();
      return {bus.out_sgn, bus.out_exp, bus.out_nan, bus.out_inf,
              bus.out_zero, bus.out_ovf, bus.out_unf};
   endfunction

   // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1,0,1,1, 2 = stalled
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: bus.out_ready = 1'b1;
            1: begin
               bus.out_ready = pat[pidx];
               pidx = (pidx + 1) % 7;
            end
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: stability during stalls and in-order scoreboard compare.
   logic [15:0] held;
   bit          stall_prev;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!bus.out_valid || got_bundle() != held) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b bundle=%h, required valid=1 bundle=%h",
                        bus.out_valid, got_bundle(), held);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: got bundle=%h, required no output", got_bundle());
            end else begin
               logic [15:0] exp_b;
               exp_b = sb_q.pop_front();
               if (got_bundle() != exp_b) begin
                  errors++;
                  $display("FAIL result: got {sgn,exp,nan,inf,zero,ovf,unf}=%h, required %h",
                           got_bundle(), exp_b);
               end
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held       = got_bundle();
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic send(input int i);
      bit ok;
      ok            = 1'b0;
      bus.sa        = vecs[i].sa;
      bus.sb        = vecs[i].sb;
      bus.expa      = vecs[i].expa;
      bus.expb      = vecs[i].expb;
      bus.mnza      = vecs[i].mnza;
      bus.mnzb      = vecs[i].mnzb;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb_q.push_back(expv(i));
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: vector %0d got not accepted, required accepted", i);
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (sb_q.size() == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
         sb_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Two register stages: out_valid is low just after the accepting edge
   // and high just after the following edge.
   task automatic send_lat(input int i);
      send(i);
      chk("latency_e0", {15'd0, bus.out_valid}, 16'd0);
      @(posedge clk);
      #1;
      chk("latency_e1", {15'd0, bus.out_valid}, 16'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rmode  = 0;
      pidx   = 0;
      pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      //            sa  sb  expa  expb  ma  mb  sgn  raw       sat       {nan,inf,zero,ovf,unf}
      vecs[0]  = mk(1, 0, 8'd130, 8'd125, 0, 0, 1, 10'd128, 10'd128, 5'b00000);
      vecs[1]  = mk(0, 0, 8'd200, 8'd200, 0, 0, 0, 10'd273, 10'd255, 5'b00010);
      vecs[2]  = mk(1, 1, 8'd10,  8'd20,  0, 0, 0, 10'h39F, 10'd0,   5'b00001);
      vecs[3]  = mk(0, 1, 8'd0,   8'd150, 0, 0, 1, 10'd23,  10'd0,   5'b00100);
      vecs[4]  = mk(0, 0, 8'd255, 8'd0,   0, 0, 0, 10'd128, 10'd255, 5'b10000);
      vecs[5]  = mk(1, 0, 8'd255, 8'd100, 0, 1, 1, 10'd228, 10'd255, 5'b01000);
      vecs[6]  = mk(0, 1, 8'd255, 8'd255, 1, 0, 1, 10'd383, 10'd255, 5'b10000);
      vecs[7]  = mk(0, 0, 8'd127, 8'd127, 1, 1, 0, 10'd127, 10'd127, 5'b00000);
      vecs[8]  = mk(1, 1, 8'd190, 8'd191, 0, 0, 0, 10'd254, 10'd254, 5'b00000);
      vecs[9]  = mk(0, 0, 8'd190, 8'd192, 0, 0, 0, 10'd255, 10'd255, 5'b00010);
      vecs[10] = mk(0, 1, 8'd63,  8'd64,  0, 0, 1, 10'd0,   10'd0,   5'b00001);
      vecs[11] = mk(0, 0, 8'd64,  8'd64,  0, 0, 0, 10'd1,   10'd1,   5'b00000);
      vecs[12] = mk(1, 0, 8'd0,   8'd200, 1, 0, 1, 10'd73,  10'd0,   5'b00100);
      vecs[13] = mk(1, 1, 8'd255, 8'd255, 1, 1, 0, 10'd383, 10'd255, 5'b10000);
      vecs[14] = mk(0, 0, 8'd0,   8'd255, 0, 0, 0, 10'd128, 10'd255, 5'b10000);
      vecs[15] = mk(1, 0, 8'd255, 8'd255, 0, 0, 1, 10'd383, 10'd255, 5'b01000);
      vecs[16] = mk(0, 0, 8'd1,   8'd1,   0, 0, 0, 10'h383, 10'd0,   5'b00001);

      bus.in_valid = 1'b0;
      bus.sa       = 1'b0;
      bus.sb       = 1'b0;
      bus.expa     = '0;
      bus.expb     = '0;
      bus.mnza     = 1'b0;
      bus.mnzb     = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      chk("reset_valid", {15'd0, bus.out_valid}, 16'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", {15'd0, bus.in_ready}, 16'd1);
      chk("reset_outputs", {bus.out_valid, got_bundle()[14:0]}, 16'd0);
      @(posedge clk);
      #1;

      // Isolated vectors with latency check
      for (int i = 0; i < 7; i++) begin
         send_lat(i);
         wait_drain();
      end

      // Back-to-back stream under the ready pattern
      rmode = 1;
      pidx  = 0;
      for (int i = 0; i < NVEC; i++) send(i);
      wait_drain();
      rmode = 0;
      repeat (2) @(posedge clk);
      #1;

      // Both stages full with downstream stalled
      rmode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(0);
      send(1);
      @(negedge clk);
      chk("full_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("full_out_valid", {15'd0, bus.out_valid}, 16'd1);

      // Reset mid-stream drops both entries at once
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {15'd0, bus.out_valid}, 16'd0);
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rmode = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_idle", {15'd0, bus.out_valid}, 16'd0);
      end
      @(posedge clk);
      #1;
      send_lat(2);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
